imem_loader: RTL and testbench

IMEM_LOADER -- requirements
Module: imem_loader

---
 rtl/imem_loader_pkg.sv | 30 +++
 rtl/imem_loader_byte_pair.sv | 34 +++
 rtl/imem_loader.sv | 175 +++++++++++++++++
 tb/tb_imem_loader.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_loader_pkg.sv
// Shared state encoding for the boot-image loader.
// CHK_HI/CHK_LO exist only when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

  localparam logic [2:0] ST_HDR_HI = 3'd0;
  localparam logic [2:0] ST_HDR_LO = 3'd1;
  localparam logic [2:0] ST_DAT_HI = 3'd2;
  localparam logic [2:0] ST_DAT_LO = 3'd3;
  localparam logic [2:0] ST_RUN    = 3'd4;
  localparam logic [2:0] ST_ERR    = 3'd5;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam logic [2:0] ST_CHK_HI = 3'd6;
  localparam logic [2:0] ST_CHK_LO = 3'd7;
`endif

  typedef enum logic [2:0] {
    HDR_HI = ST_HDR_HI,
    HDR_LO = ST_HDR_LO,
    DAT_HI = ST_DAT_HI,
    DAT_LO = ST_DAT_LO,
    RUN    = ST_RUN,
    ERR    = ST_ERR
`ifdef IMEM_LOADER_CHECKSUM_EN
    ,
    CHK_HI = ST_CHK_HI,
    CHK_LO = ST_CHK_LO
`endif
  } state_e;

endpackage

// File: rtl/imem_loader_byte_pair.sv
// Big-endian byte pairing: latches the high byte, exposes {hi,byte} combinationally
// and a registered word with a one-cycle valid strobe for the memory write.
module byte_pair (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  byte_i,
  input  logic        hi_we_i,
  input  logic        lo_we_i,
  output logic [15:0] pair_o,
  output logic [15:0] word_o,
  output logic        word_valid_o
);

  logic [7:0]  hi_q;
  logic [15:0] word_q;
  logic        valid_q;

  assign pair_o       = {hi_q, byte_i};
  assign word_o       = word_q;
  assign word_valid_o = valid_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q    <= 8'h00;
      word_q  <= 16'h0000;
      valid_q <= 1'b0;
    end else begin
      valid_q <= lo_we_i;
      if (hi_we_i) hi_q <= byte_i;
      if (lo_we_i) word_q <= pair_o;
    end
  end

endmodule

// File: rtl/imem_loader.sv
// Serial boot loader: parses a big-endian word-count image into instruction memory,
// then releases the CPU. Optional checksum stage via IMEM_LOADER_CHECKSUM_EN.
import imem_loader_pkg::*;

module imem_loader #(
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    rx_data,
  input  logic          rx_valid,
  input  logic          load_req,
  input  logic [15:0]   pc,
  output logic [AW-1:0] mem_addr,
  output logic [15:0]   mem_wdata,
  output logic          mem_we,
  output logic          cpu_reset,
  output logic          busy,
  output logic          error
);

  localparam logic [16:0] DEPTH_W = 17'(DEPTH);

  state_e        state_q, state_d;
  logic [AW:0]   addr_q, addr_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic          done_q, done_d;
  logic [15:0]   pair;
  logic [15:0]   word;
  logic          word_valid;
  logic          hi_we, lo_we;
  logic [AW:0]   addr_inc;
  logic          last_word;
  logic          unused_pc;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [15:0]   acc_q, acc_d;
`endif

  assign unused_pc = ^pc[15:AW];
  assign addr_inc  = addr_q + 1'b1;
  assign last_word = (addr_inc == count_q);

  assign hi_we = rx_valid && ((state_q == HDR_HI) || (state_q == DAT_HI)
`ifdef IMEM_LOADER_CHECKSUM_EN
                              || (state_q == CHK_HI)
`endif
                             );
  // done_q marks a final word whose write is still in flight; stray bytes are not words.
  assign lo_we = rx_valid && (state_q == DAT_LO) && !done_q;

  byte_pair u_byte_pair (
    .clk          (clk),
    .rst_n        (rst_n),
    .byte_i       (rx_data),
    .hi_we_i      (hi_we),
    .lo_we_i      (lo_we),
    .pair_o       (pair),
    .word_o       (word),
    .word_valid_o (word_valid)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= HDR_HI;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      HDR_HI: if (rx_valid) state_d = HDR_LO;
      HDR_LO: begin
        if (rx_valid) begin
          if (pair == 16'h0000) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = CHK_HI;
`else
            state_d = RUN;
`endif
          end else if ({1'b0, pair} > DEPTH_W) begin
            state_d = ERR;
          end else begin
            state_d = DAT_HI;
          end
        end
      end
      DAT_HI: if (rx_valid) state_d = DAT_LO;
      DAT_LO: begin
        // Without a checksum, RUN is entered only after the final write cycle so the
        // CPU never sees the memory port borrowed by the loader.
        if (done_q) begin
          state_d = RUN;
        end else if (rx_valid) begin
          if (last_word) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = CHK_HI;
`else
            state_d = DAT_LO;
`endif
          end else begin
            state_d = DAT_HI;
          end
        end
      end
      RUN: if (load_req) state_d = HDR_HI;
      ERR: if (load_req) state_d = HDR_HI;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CHK_HI: if (rx_valid) state_d = CHK_LO;
      CHK_LO: if (rx_valid) state_d = (pair == acc_q) ? RUN : ERR;
`endif
      default: state_d = HDR_HI;
    endcase
  end

  always_comb begin
    cpu_reset = (state_q != RUN);
    busy      = (state_q != RUN);
    error     = (state_q == ERR);
  end

  always_comb begin
    addr_d    = addr_q;
    count_d   = count_q;
    wr_addr_d = wr_addr_q;
    done_d    = done_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    acc_d     = acc_q;
`endif
    if (state_q == HDR_HI) begin
      done_d = 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      acc_d  = 16'h0000;
`endif
    end
    if ((state_q == HDR_LO) && rx_valid) begin
      count_d = pair[AW:0];
      addr_d  = '0;
    end
    if (lo_we) begin
      wr_addr_d = addr_q[AW-1:0];
      addr_d    = addr_inc;
`ifdef IMEM_LOADER_CHECKSUM_EN
      acc_d     = acc_q + pair;
`else
      done_d    = last_word;
`endif
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q    <= '0;
      count_q   <= '0;
      wr_addr_q <= '0;
      done_q    <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
      acc_q     <= 16'h0000;
`endif
    end else begin
      addr_q    <= addr_d;
      count_q   <= count_d;
      wr_addr_q <= wr_addr_d;
      done_q    <= done_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
      acc_q     <= acc_d;
`endif
    end
  end

  assign mem_we    = word_valid;
  assign mem_wdata = word;
  assign mem_addr  = word_valid ? wr_addr_q : pc[AW-1:0];

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: image-level write model plus literal spot checks.
// Checksum scenarios run when IMEM_LOADER_CHECKSUM_EN is defined.
`timescale 1ns/1ps
module tb_imem_loader;

  localparam int DEPTH = 256;
  localparam int AW    = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          load_req = 1'b0;
  logic [15:0]   pc = 16'h0000;
  logic [AW-1:0] mem_addr;
  logic [15:0]   mem_wdata;
  logic          mem_we;
  logic          cpu_reset;
  logic          busy;
  logic          error;

  always #5 clk = ~clk;

  imem_loader #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid),
    .load_req  (load_req),
    .pc        (pc),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .cpu_reset (cpu_reset),
    .busy      (busy),
    .error     (error)
  );

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [15:0]   data;
  } wr_t;

  int          pass_cnt = 0;
  int          total_cnt = 0;
  wr_t         exp_q[$];
  logic [15:0] img_q[$];

  task automatic check(input string name, input int act, input int exp);
    total_cnt++;
    if (act == exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Every cycle: a write must match the next expected image word, otherwise the port follows pc.
  always @(negedge clk) begin : compare
    wr_t e;
    if (mem_we) begin
      if (exp_q.size() == 0) begin
        check("unexpected_write", int'(mem_we), 0);
      end else begin
        e = exp_q.pop_front();
        check("wr_addr", int'(mem_addr), int'(e.addr));
        check("wr_data", int'(mem_wdata), int'(e.data));
      end
    end else begin
      check("idle_addr", int'(mem_addr), int'(pc[AW-1:0]));
    end
    check("busy_vs_cpu_reset", int'(busy), int'(cpu_reset));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input int a, input logic [15:0] d);
    wr_t w;
    w.addr = AW'(a);
    w.data = d;
    exp_q.push_back(w);
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data  = b;
    rx_valid = 1'b1;
    tick();
    rx_valid = 1'b0;
    repeat (gap) tick();
  endtask

  task automatic send_word(input logic [15:0] w, input int gap);
    send_byte(w[15:8], gap);
    send_byte(w[7:0], gap);
  endtask

  // Sends header n, the words in img_q (expecting each at its index) and, if enabled, the sum.
  task automatic send_image(input logic [15:0] n, input int gap);
    logic [15:0] sum;
    sum = 16'h0000;
    send_word(n, gap);
    for (int i = 0; i < img_q.size(); i++) begin
      push_exp(i, img_q[i]);
      sum = sum + img_q[i];
      send_word(img_q[i], gap);
    end
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(sum, gap);
`endif
    $display("image N=%0d sent (gap %0d)", n, gap);
  endtask

  task automatic pulse_load();
    load_req = 1'b1;
    tick();
    load_req = 1'b0;
  endtask

  initial begin
    // Reset values
    #2;
    check("rst_cpu_reset", int'(cpu_reset), 1);
    check("rst_busy", int'(busy), 1);
    check("rst_error", int'(error), 0);
    check("rst_mem_we", int'(mem_we), 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    tick();

    // Two-word image with spaced strobes, literal expectations
    pc = 16'h0005;
    send_word(16'h0002, 1);
    push_exp(0, 16'h1234);
    push_exp(1, 16'hABCD);
    send_word(16'h1234, 1);
    send_word(16'hABCD, 0);
    check("t1_second_write_we", int'(mem_we), 1);
    check("t1_second_write_addr", int'(mem_addr), 1);
    check("t1_second_write_data", int'(mem_wdata), 16'hABCD);
    check("t1_cpu_reset_during_write", int'(cpu_reset), 1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(16'hBE01, 0);
`else
    tick();
`endif
    check("t1_cpu_released", int'(cpu_reset), 0);
    check("t1_busy", int'(busy), 0);
    check("t1_pc_addr", int'(mem_addr), 8'h05);
    $display("txn t1 two-word image: run");

    // Oversized header -> ERR, then recover with an empty image
    pulse_load();
    pc = 16'h0033;
    send_word(16'h0101, 0);
    check("t2_error", int'(error), 1);
    check("t2_cpu_reset", int'(cpu_reset), 1);
    repeat (3) tick();
    check("t2_error_held", int'(error), 1);
    pulse_load();
    check("t2_error_cleared", int'(error), 0);
    check("t2_busy_after_load", int'(busy), 1);
    img_q = {};
    send_image(16'h0000, 0);
    tick();
    check("t2_run", int'(cpu_reset), 0);
    $display("txn t2 oversize header then empty image");

    // Reset in the middle of a three-word image
    pulse_load();
    check("t3_reload_cpu_reset", int'(cpu_reset), 1);
    send_word(16'h0003, 0);
    push_exp(0, 16'h1111);
    send_word(16'h1111, 0);
    send_byte(8'h22, 0);
    #2 rst_n = 1'b0;
    #1;
    check("t3_async_cpu_reset", int'(cpu_reset), 1);
    check("t3_async_busy", int'(busy), 1);
    check("t3_async_error", int'(error), 0);
    check("t3_async_we", int'(mem_we), 0);
    tick();
    rst_n = 1'b1;
    tick();
    img_q = {16'hC0DE};
    send_image(16'h0001, 0);
    tick();
    check("t3_run", int'(cpu_reset), 0);
    $display("txn t3 reset mid-load then fresh image");

    // Full-depth image with back-to-back strobes
    pulse_load();
    pc = 16'h00F0;
    img_q = {};
    for (int i = 0; i < DEPTH; i++) img_q.push_back(16'((i * 16'h0101) ^ 16'h5A3C));
    send_image(16'(DEPTH), 0);
    tick();
    check("t4_run", int'(cpu_reset), 0);
    check("t4_all_written", exp_q.size(), 0);
    $display("txn t4 full-depth image");

    // load_req wins over a simultaneous stray byte
    rx_data  = 8'h7F;
    rx_valid = 1'b1;
    load_req = 1'b1;
    tick();
    rx_valid = 1'b0;
    load_req = 1'b0;
    check("t5_reload", int'(cpu_reset), 1);
    img_q = {16'h5A5A};
    send_image(16'h0001, 0);
    tick();
    check("t5_error", int'(error), 0);
    check("t5_run", int'(cpu_reset), 0);
    $display("txn t5 load_req with stray byte");

`ifdef IMEM_LOADER_CHECKSUM_EN
    pulse_load();
    send_word(16'h0001, 0);
    push_exp(0, 16'h0005);
    send_word(16'h0005, 0);
    send_word(16'h0005, 0);
    check("t6_good_sum_run", int'(cpu_reset), 0);
    check("t6_good_sum_error", int'(error), 0);
    $display("txn t6 good checksum");
    pulse_load();
    send_word(16'h0001, 0);
    push_exp(0, 16'h0005);
    send_word(16'h0005, 0);
    send_word(16'h0006, 0);
    check("t7_bad_sum_error", int'(error), 1);
    check("t7_bad_sum_cpu_reset", int'(cpu_reset), 1);
    $display("txn t7 bad checksum");
`endif

    repeat (3) tick();
    check("pending_writes", exp_q.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
